// File: rtl/fsm_control.sv
// fsm_control: supervisory state machine for the switch output stage.
// Walks the block through RESET, INIT, IDLE, ACTIVE and ERROR, holds the
// almost-full/almost-empty thresholds captured during INIT, turns FIFO
// occupancy into per-FIFO flow-control flags, and flags when the stage is
// idle so the pop-count reporting logic can release its counts.
module fsm_control #(
    parameter int FIFO_UNITS = 4,
    parameter int DEPTH_BITS = 3
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 init,
    input  logic [DEPTH_BITS:0]                  umbral_bajo_in,
    input  logic [DEPTH_BITS:0]                  umbral_alto_in,
    input  logic [FIFO_UNITS-1:0]                fifo_empty,
    input  logic [FIFO_UNITS-1:0]                fifo_error,
    input  logic [FIFO_UNITS*(DEPTH_BITS+1)-1:0] fifo_count,
    output logic [2:0]                           state,
    output logic [DEPTH_BITS:0]                  umbral_bajo,
    output logic [DEPTH_BITS:0]                  umbral_alto,
    output logic                                 idle,
    output logic                                 error_out,
    output logic [FIFO_UNITS-1:0]                error_vec,
    output logic [FIFO_UNITS-1:0]                almost_full,
    output logic [FIFO_UNITS-1:0]                almost_empty
);

    localparam int CW = DEPTH_BITS + 1;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    state_t                cur_state;
    state_t                next_state;
    logic                  any_error;
    logic                  all_empty;
    logic                  flags_live;
    logic [FIFO_UNITS-1:0] full_next;
    logic [FIFO_UNITS-1:0] empty_next;

    assign any_error  = |fifo_error;
    assign all_empty  = &fifo_empty;
    assign flags_live = (cur_state == ST_IDLE) || (cur_state == ST_ACTIVE);

    assign state     = cur_state;
    assign idle      = (cur_state == ST_IDLE);
    assign error_out = (cur_state == ST_ERROR);

    // State register; reset wins over every transition, including out of ERROR.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cur_state <= ST_RESET;
        end else begin
            cur_state <= next_state;
        end
    end

    // Next-state logic: errors beat init, init beats the empty-driven moves.
    always_comb begin
        next_state = cur_state;
        case (cur_state)
            ST_RESET: begin
                next_state = ST_INIT;
            end
            ST_INIT: begin
                if (any_error) begin
                    next_state = ST_ERROR;
                end else if (init) begin
                    next_state = ST_INIT;
                end else if (all_empty) begin
                    next_state = ST_IDLE;
                end else begin
                    next_state = ST_ACTIVE;
                end
            end
            ST_IDLE: begin
                if (any_error) begin
                    next_state = ST_ERROR;
                end else if (init) begin
                    next_state = ST_INIT;
                end else if (!all_empty) begin
                    next_state = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (any_error) begin
                    next_state = ST_ERROR;
                end else if (init) begin
                    next_state = ST_INIT;
                end else if (all_empty) begin
                    next_state = ST_IDLE;
                end
            end
            ST_ERROR: begin
                next_state = ST_ERROR;
            end
            default: begin
                next_state = ST_RESET;
            end
        endcase
    end

    // Thresholds follow the inputs every INIT cycle and are frozen elsewhere.
    always_ff @(posedge clk) begin
        if (!reset) begin
            umbral_bajo <= '0;
            umbral_alto <= '0;
        end else if (cur_state == ST_INIT) begin
            umbral_bajo <= umbral_bajo_in;
            umbral_alto <= umbral_alto_in;
        end
    end

    // Error capture: snapshot on the entry edge, then accumulate while in ERROR.
    always_ff @(posedge clk) begin
        if (!reset) begin
            error_vec <= '0;
        end else if (cur_state == ST_ERROR) begin
            error_vec <= error_vec | fifo_error;
        end else if (next_state == ST_ERROR) begin
            error_vec <= fifo_error;
        end
    end

    // Per-FIFO unsigned threshold compares; degenerate thresholds pass through as-is.
    always_comb begin
        full_next  = '0;
        empty_next = '0;
        for (int i = 0; i < FIFO_UNITS; i++) begin
            full_next[i]  = (fifo_count[i*CW +: CW] >= umbral_alto);
            empty_next[i] = (fifo_count[i*CW +: CW] <= umbral_bajo);
        end
    end

    // Flags are registered while moving traffic and forced low in the other states.
    always_ff @(posedge clk) begin
        if (!reset) begin
            almost_full  <= '0;
            almost_empty <= '0;
        end else if (flags_live) begin
            almost_full  <= full_next;
            almost_empty <= empty_next;
        end else begin
            almost_full  <= '0;
            almost_empty <= '0;
        end
    end

endmodule
